// File: rtl/mcs6530_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riot_bus_pkg
// Description : Shared types and constants for the mcs6530 RRIOT bus master:
//               command select and FSM state enums, (rs_n, cs2, cs1) select
//               triples and the default idle address.
// Revision    : 1.0 - initial release
// ============================================================================
package riot_bus_pkg;

  typedef enum logic [1:0] {
    SEL_ROM   = 2'd0,
    SEL_RAMIO = 2'd1,
    SEL_TIMER = 2'd2,
    SEL_RSVD  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SAMPLE = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Select triples, packed as {rs_n, cs2, cs1}
  localparam logic [2:0] C_SELENC_ROM   = 3'b000;
  localparam logic [2:0] C_SELENC_RAMIO = 3'b110;
  localparam logic [2:0] C_SELENC_TIMER = 3'b111;
  localparam logic [2:0] C_SELENC_IDLE  = C_SELENC_RAMIO;

  // Idle address is a RAM read: reading it has no side effects
  localparam logic [9:0] C_IDLE_ADDR_DEF = 10'h3FF;
  localparam int         C_LEN_W_DEF     = 4;

  // Map a command select onto the peripheral select triple
  function automatic logic [2:0] sel_encode(input sel_e sel);
    case (sel)
      SEL_ROM:   sel_encode = C_SELENC_ROM;
      SEL_RAMIO: sel_encode = C_SELENC_RAMIO;
      SEL_TIMER: sel_encode = C_SELENC_TIMER;
      default:   sel_encode = C_SELENC_IDLE;
    endcase
  endfunction

endpackage : riot_bus_pkg
`default_nettype wire

// File: rtl/mcs6530_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : mcs6530_bus_master_if
// Description : Command, response and peripheral-bus signals of the mcs6530
//               bus master. The master modport is the initiator side; the
//               slave modport is the command source / peripheral side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mcs6530_bus_master_if
  import riot_bus_pkg::*;
#(
  parameter int LEN_W = C_LEN_W_DEF
);

  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [1:0]       cmd_sel;
  logic [9:0]       cmd_addr;
  logic [7:0]       cmd_wdata;
  logic [LEN_W-1:0] cmd_len;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             rsp_last;

  // Peripheral bus
  logic             bus_we_n;
  logic [9:0]       bus_a;
  logic [7:0]       bus_di;
  logic             bus_rs_n;
  logic             bus_cs1;
  logic             bus_cs2;
  logic [7:0]       bus_do;
  logic             bus_oe;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_wdata, cmd_len,
    input  rsp_ready, bus_do, bus_oe,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last,
    output bus_we_n, bus_a, bus_di, bus_rs_n, bus_cs1, bus_cs2
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_wdata, cmd_len,
    output rsp_ready, bus_do, bus_oe,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last,
    input  bus_we_n, bus_a, bus_di, bus_rs_n, bus_cs1, bus_cs2
  );

endinterface : mcs6530_bus_master_if
`default_nettype wire

// File: rtl/mcs6530_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mcs6530_bus_master
// Description : Bus initiator for the mcs6530 RRIOT. Accepts ROM, RAM/IO and
//               timer commands (single or burst), drives we_n/A/DI/RS_n/CS1/
//               CS2 and returns one response per read beat, one per write
//               command. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mcs6530_bus_master
  import riot_bus_pkg::*;
#(
  parameter logic [9:0] IDLE_ADDR = C_IDLE_ADDR_DEF,
  parameter int         LEN_W     = C_LEN_W_DEF
) (
  input  wire logic             phi2,
  input  wire logic             rst_n,
  mcs6530_bus_master_if.master  bus
);

  localparam logic [LEN_W-1:0] C_CNT_ONE = LEN_W'(1);

  state_e           r_state, w_state;
  logic             r_we, w_we;
  sel_e             r_sel, w_sel;
  logic [9:0]       r_addr, w_addr;
  logic [7:0]       r_wdata, w_wdata;
  logic [LEN_W-1:0] r_cnt, w_cnt;

  logic             r_cmd_ready, w_cmd_ready;
  logic             r_rsp_valid, w_rsp_valid;
  logic [7:0]       r_rsp_data, w_rsp_data;
  logic             r_rsp_err, w_rsp_err;
  logic             r_rsp_last, w_rsp_last;
  logic             r_bus_we_n, w_bus_we_n;
  logic [9:0]       r_bus_a, w_bus_a;
  logic [7:0]       r_bus_di, w_bus_di;
  logic [2:0]       r_bus_sel, w_bus_sel;

  logic [9:0]       w_addr_inc;
  logic             w_cmd_fire;

  // Address increment wraps naturally at 10 bits
  assign w_addr_inc = r_addr + 10'd1;
  assign w_cmd_fire = r_cmd_ready & bus.cmd_valid;

  // State register; reset aborts any command in flight
  always_ff @(posedge phi2) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state;
  end

  // Command context, response and bus registers
  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_sel       <= SEL_ROM;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_bus_we_n  <= 1'b1;
      r_bus_a     <= IDLE_ADDR;
      r_bus_di    <= '0;
      r_bus_sel   <= C_SELENC_IDLE;
    end else begin
      r_we        <= w_we;
      r_sel       <= w_sel;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_cnt       <= w_cnt;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_err   <= w_rsp_err;
      r_rsp_last  <= w_rsp_last;
      r_bus_we_n  <= w_bus_we_n;
      r_bus_a     <= w_bus_a;
      r_bus_di    <= w_bus_di;
      r_bus_sel   <= w_bus_sel;
    end
  end

  // Next-state and next-output logic; bus defaults to the idle read
  always_comb begin
    w_state     = r_state;
    w_we        = r_we;
    w_sel       = r_sel;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_cnt       = r_cnt;
    w_cmd_ready = 1'b0;
    w_rsp_valid = r_rsp_valid;
    w_rsp_data  = r_rsp_data;
    w_rsp_err   = r_rsp_err;
    w_rsp_last  = r_rsp_last;
    w_bus_we_n  = 1'b1;
    w_bus_a     = IDLE_ADDR;
    w_bus_di    = '0;
    w_bus_sel   = C_SELENC_IDLE;

    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (w_cmd_fire) begin
          w_cmd_ready = 1'b0;
          w_we        = bus.cmd_we;
          w_sel       = sel_e'(bus.cmd_sel);
          w_addr      = bus.cmd_addr;
          w_wdata     = bus.cmd_wdata;
          w_cnt       = bus.cmd_len;
          if (sel_e'(bus.cmd_sel) == SEL_RSVD) begin
            // Reserved select never touches the bus
            w_state     = RESP;
            w_rsp_valid = 1'b1;
            w_rsp_data  = '0;
            w_rsp_err   = 1'b1;
            w_rsp_last  = 1'b1;
          end else begin
            w_state    = ISSUE;
            w_bus_we_n = ~bus.cmd_we;
            w_bus_a    = bus.cmd_addr;
            w_bus_di   = bus.cmd_wdata;
            w_bus_sel  = sel_encode(sel_e'(bus.cmd_sel));
          end
        end
      end

      ISSUE: begin
        if (r_we) begin
          if (r_cnt != '0) begin
            // Back-to-back write beats keep the strobe low
            w_cnt      = r_cnt - C_CNT_ONE;
            w_addr     = w_addr_inc;
            w_bus_we_n = 1'b0;
            w_bus_a    = w_addr_inc;
            w_bus_di   = r_wdata;
            w_bus_sel  = sel_encode(r_sel);
          end else begin
            w_state     = RESP;
            w_rsp_valid = 1'b1;
            w_rsp_data  = '0;
            w_rsp_err   = 1'b0;
            w_rsp_last  = 1'b1;
          end
        end else begin
          w_state = SAMPLE;
        end
      end

      SAMPLE: begin
        // Peripheral DO/OE were registered on the previous edge
        w_state     = RESP;
        w_rsp_valid = 1'b1;
        w_rsp_data  = bus.bus_oe ? bus.bus_do : 8'h00;
        w_rsp_err   = ~bus.bus_oe;
        w_rsp_last  = (r_cnt == '0);
      end

      RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_valid = 1'b0;
          if (r_rsp_last) begin
            w_state     = IDLE;
            w_cmd_ready = 1'b1;
          end else begin
            w_state    = ISSUE;
            w_cnt      = r_cnt - C_CNT_ONE;
            w_addr     = w_addr_inc;
            w_bus_we_n = ~r_we;
            w_bus_a    = w_addr_inc;
            w_bus_di   = r_wdata;
            w_bus_sel  = sel_encode(r_sel);
          end
        end
      end

      default: w_state = IDLE;
    endcase
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.bus_we_n  = r_bus_we_n;
  assign bus.bus_a     = r_bus_a;
  assign bus.bus_di    = r_bus_di;
  assign bus.bus_rs_n  = r_bus_sel[2];
  assign bus.bus_cs2   = r_bus_sel[1];
  assign bus.bus_cs1   = r_bus_sel[0];

endmodule : mcs6530_bus_master
`default_nettype wire

// File: tb/tb_mcs6530_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcs6530_bus_master
// Description : Directed self-checking bench for mcs6530_bus_master with a
//               small registered peripheral model (ROM pattern, RAM array,
//               timer without OE).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcs6530_bus_master;
  import riot_bus_pkg::*;

  logic phi2 = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] ram [0:1023];

  always #5 phi2 = ~phi2;

  mcs6530_bus_master_if #(.LEN_W(4)) bus_if ();

  mcs6530_bus_master #(.IDLE_ADDR(10'h3FF), .LEN_W(4)) dut (
    .phi2  (phi2),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  function automatic logic [7:0] rom_val(input logic [9:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ram_init(input logic [9:0] a);
    return a[7:0] + 8'h11;
  endfunction

  function automatic logic [2:0] sel_now();
    return {bus_if.bus_rs_n, bus_if.bus_cs2, bus_if.bus_cs1};
  endfunction

  // Peripheral model: registered DO/OE, RAM write on we_n low
  always @(posedge phi2) begin
    if (!bus_if.bus_rs_n) begin
      bus_if.bus_do <= rom_val(bus_if.bus_a);
      bus_if.bus_oe <= 1'b1;
    end else if (bus_if.bus_cs1) begin
      bus_if.bus_do <= 8'hEE;
      bus_if.bus_oe <= 1'b0;
    end else if (!bus_if.bus_we_n) begin
      ram[bus_if.bus_a] <= bus_if.bus_di;
      bus_if.bus_oe     <= 1'b0;
    end else begin
      bus_if.bus_do <= ram[bus_if.bus_a];
      bus_if.bus_oe <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  // Offer a command once cmd_ready is seen; returns just after the handshake edge
  task automatic send_cmd(input logic we, input logic [1:0] sel, input logic [9:0] addr,
                          input logic [7:0] wd, input logic [3:0] len);
    int n;
    n = 0;
    while (bus_if.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus_if.cmd_ready !== 1'b1) chk("cmd_ready_timeout", {31'd0, bus_if.cmd_ready}, 32'd1);
    bus_if.cmd_we    = we;
    bus_if.cmd_sel   = sel;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wd;
    bus_if.cmd_len   = len;
    bus_if.cmd_valid = 1'b1;
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) ram[i] = ram_init(10'(i));
    bus_if.bus_do    = 8'h00;
    bus_if.bus_oe    = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_sel   = 2'd0;
    bus_if.cmd_addr  = 10'd0;
    bus_if.cmd_wdata = 8'd0;
    bus_if.cmd_len   = 4'd0;
    bus_if.rsp_ready = 1'b1;

    // Reset values
    tick(); tick(); tick();
    chk("rst_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
    chk("rst_rsp", {22'd0, bus_if.rsp_data, bus_if.rsp_err, bus_if.rsp_last}, 32'd0);
    chk("rst_we_n", {31'd0, bus_if.bus_we_n}, 32'd1);
    chk("rst_bus_a", {22'd0, bus_if.bus_a}, 32'h3FF);
    chk("rst_bus_di", {24'd0, bus_if.bus_di}, 32'd0);
    chk("rst_sel", {29'd0, sel_now()}, 32'b110);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, bus_if.cmd_ready}, 32'd1);

    // ROM read of address 0
    send_cmd(1'b0, 2'd0, 10'h000, 8'h00, 4'd0);
    chk("rom_sel", {29'd0, sel_now()}, 32'b000);
    chk("rom_a", {22'd0, bus_if.bus_a}, 32'h000);
    chk("rom_ready_low", {31'd0, bus_if.cmd_ready}, 32'd0);
    tick();
    chk("rom_sel_idle", {29'd0, sel_now()}, 32'b110);
    chk("rom_no_rsp_e1", {31'd0, bus_if.rsp_valid}, 32'd0);
    tick();
    chk("rom_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
    chk("rom_rsp", {22'd0, bus_if.rsp_data, bus_if.rsp_err, bus_if.rsp_last}, {22'd0, rom_val(10'h000), 2'b01});
    tick();
    chk("rom_rsp_done", {31'd0, bus_if.rsp_valid}, 32'd0);
    chk("rom_ready_back", {31'd0, bus_if.cmd_ready}, 32'd1);

    // RAM write then read back
    send_cmd(1'b1, 2'd1, 10'h385, 8'hA5, 4'd0);
    chk("wr_bus", {bus_if.bus_we_n, 1'b0, bus_if.bus_a, 4'd0, bus_if.bus_di, 5'd0, sel_now()},
        {1'b0, 1'b0, 10'h385, 4'd0, 8'hA5, 5'd0, 3'b110});
    tick();
    chk("wr_we_n_high", {31'd0, bus_if.bus_we_n}, 32'd1);
    chk("wr_rsp", {21'd0, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_err, bus_if.rsp_last}, {21'd0, 1'b1, 8'h00, 2'b01});
    tick();
    chk("wr_one_rsp", {31'd0, bus_if.rsp_valid}, 32'd0);
    chk("wr_we_n_stays", {31'd0, bus_if.bus_we_n}, 32'd1);
    send_cmd(1'b0, 2'd1, 10'h385, 8'h00, 4'd0);
    tick(); tick();
    chk("rd_back", {21'd0, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_err, bus_if.rsp_last}, {21'd0, 1'b1, 8'hA5, 2'b01});
    tick();

    // Burst read with backpressure on beat 1
    send_cmd(1'b0, 2'd1, 10'h380, 8'h00, 4'd3);
    for (int b = 0; b < 4; b++) begin
      a = 10'h380 + 10'(b);
      chk("burst_a", {22'd0, bus_if.bus_a}, {22'd0, a});
      tick(); tick();
      chk("burst_rsp", {21'd0, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_err, bus_if.rsp_last},
          {21'd0, 1'b1, ram_init(a), 1'b0, (b == 3)});
      if (b == 1) begin
        bus_if.rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_rsp", {23'd0, bus_if.rsp_valid, bus_if.rsp_data}, {23'd0, 1'b1, ram_init(a)});
          chk("stall_bus", {21'd0, bus_if.bus_we_n, bus_if.bus_a}, {21'd0, 1'b1, 10'h3FF});
        end
        bus_if.rsp_ready = 1'b1;
      end
      tick();
    end
    chk("burst_done", {30'd0, bus_if.rsp_valid, bus_if.cmd_ready}, 32'b01);

    // Write burst wrapping past 3FF
    send_cmd(1'b1, 2'd1, 10'h3FE, 8'h5A, 4'd2);
    chk("wrap_0", {21'd0, bus_if.bus_we_n, bus_if.bus_a}, {21'd0, 1'b0, 10'h3FE});
    tick();
    chk("wrap_1", {21'd0, bus_if.bus_we_n, bus_if.bus_a}, {21'd0, 1'b0, 10'h3FF});
    tick();
    chk("wrap_2", {21'd0, bus_if.bus_we_n, bus_if.bus_a}, {21'd0, 1'b0, 10'h000});
    tick();
    chk("wrap_idle", {21'd0, bus_if.bus_we_n, bus_if.bus_a}, {21'd0, 1'b1, 10'h3FF});
    chk("wrap_rsp", {29'd0, bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_last}, 32'b101);
    tick();
    chk("wrap_ram", {24'd0, ram[0]}, 32'h5A);

    // Timer read returns an error
    send_cmd(1'b0, 2'd2, 10'h004, 8'h00, 4'd0);
    chk("tmr_sel", {29'd0, sel_now()}, 32'b111);
    tick(); tick();
    chk("tmr_rsp", {21'd0, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_err, bus_if.rsp_last}, {21'd0, 1'b1, 8'h00, 2'b11});
    tick();

    // Reserved select: immediate error, no bus activity
    send_cmd(1'b1, 2'd3, 10'h123, 8'hFF, 4'd0);
    chk("rsvd_rsp", {21'd0, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_err, bus_if.rsp_last}, {21'd0, 1'b1, 8'h00, 2'b11});
    chk("rsvd_bus", {18'd0, bus_if.bus_we_n, bus_if.bus_a, sel_now()}, {18'd0, 1'b1, 10'h3FF, 3'b110});
    tick();
    chk("rsvd_done", {30'd0, bus_if.rsp_valid, bus_if.cmd_ready}, 32'b01);

    // Reset during beat 2 of an 8-beat read
    send_cmd(1'b0, 2'd1, 10'h010, 8'h00, 4'd7);
    tick(); tick();
    chk("rb_beat0", {24'd0, bus_if.rsp_data}, {24'd0, ram_init(10'h010)});
    tick(); tick(); tick(); tick();
    chk("rb_beat2_a", {22'd0, bus_if.bus_a}, 32'h012);
    rst_n = 1'b0;
    tick();
    chk("rb_idle_bus", {18'd0, bus_if.bus_we_n, bus_if.bus_a, sel_now()}, {18'd0, 1'b1, 10'h3FF, 3'b110});
    chk("rb_ready_low", {30'd0, bus_if.cmd_ready, bus_if.rsp_valid}, 32'b00);
    tick(); tick();
    chk("rb_no_rsp", {30'd0, bus_if.cmd_ready, bus_if.rsp_valid}, 32'b00);
    rst_n = 1'b1;
    tick();
    chk("rb_ready_after", {31'd0, bus_if.cmd_ready}, 32'd1);
    send_cmd(1'b0, 2'd0, 10'h005, 8'h00, 4'd0);
    tick(); tick();
    chk("rb_new_cmd", {21'd0, bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_err, bus_if.rsp_last}, {21'd0, 1'b1, 8'h39, 2'b01});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mcs6530_bus_master
`default_nettype wire

// File: doc/mcs6530_bus_master.md
Name: mcs6530_bus_master

Overview:
Bus initiator for the mcs6530-class RRIOT peripheral, clocked on phi2. It accepts ROM, RAM/IO and timer access commands over a valid/ready interface and drives the peripheral's we_n, A, DI, RS_n, CS1 and CS2 lines. It samples the peripheral's registered DO/OE response and returns one response per read beat. It serves as the bring-up, test and boot-copy engine on the CPU side of the bus.

Parameters:
IDLE_ADDR, 10'h3FF, address driven while idle (RAM read, side-effect free)
LEN_W, 4, width of the cmd_len beat-count field (bursts of 1..2^LEN_W beats)

Ports:
phi2  in  1  clock; all logic on posedge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  master can accept a command
cmd_we  in  1  1=write, 0=read
cmd_sel  in  2  0=ROM, 1=RAM/IO, 2=timer, 3=reserved
cmd_addr  in  10  start address
cmd_wdata  in  8  write data, repeated on every beat of a write burst
cmd_len  in  LEN_W  beats minus one
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  read data; 0 for write or error responses
rsp_err  out  1  OE absent at sample point, or reserved sel
rsp_last  out  1  final response of the command
bus_we_n  out  1  to peripheral we_n
bus_a  out  10  to peripheral A
bus_di  out  8  to peripheral DI
bus_rs_n  out  1  ROM select, active-low
bus_cs1  out  1  to PBI[6]
bus_cs2  out  1  to PBI[5]
bus_do  in  8  peripheral DO
bus_oe  in  1  peripheral OE

Behaviour:
- All outputs are registered.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_last=0, bus_we_n=1, bus_a=IDLE_ADDR, bus_di=0, bus_rs_n=1, bus_cs1=0, bus_cs2=1.
- Reset asserted mid-command aborts the command. No response is issued and the bus returns to the idle values on the same edge.
- Select encoding (rs_n, cs2, cs1):
  - ROM = 0, 0, 0
  - RAM/IO = 1, 1, 0
  - timer = 1, 1, 1
  - idle = RAM/IO encoding with IDLE_ADDR and we_n=1
- FSM states: IDLE, ISSUE, SAMPLE, RESP.
- IDLE:
  - cmd_ready=1. Command handshake occurs at edge E0.
  - Latch the command; beat counter = cmd_len.
  - cmd_sel=3: go straight to RESP with err=1, last=1, data=0. No bus activity.
  - Otherwise: drive the bus for beat 0 at E0 and enter ISSUE.
- ISSUE (one cycle per beat, bus valid E0..E1):
  - bus_we_n = ~cmd_we; bus_a = current address; bus_di = wdata.
  - Write, more beats remaining: at E1 drive the next address (still we_n=0) and stay in ISSUE.
  - Write, final beat: at E1 drive the idle bus and enter RESP with err=0, last=1, data=0. A write command produces exactly one response.
  - Read: at E1 drive the idle bus and enter SAMPLE.
- SAMPLE:
  - At E2 capture bus_oe/bus_do.
  - rsp_data = bus_oe ? bus_do : 0; rsp_err = ~bus_oe.
  - rsp_last = (beat counter == 0). Enter RESP.
  - Read latency: address presented E0, rsp_valid high from E2.
- RESP:
  - rsp_valid held with stable data until rsp_valid && rsp_ready.
  - On handshake, if not last: decrement the beat counter, increment the address, drive the next beat's bus, enter ISSUE.
  - On handshake, if last: enter IDLE with cmd_ready=1 on the next cycle.
  - The bus stays idle (we_n=1) for the whole RESP period. Backpressure never stretches a write strobe.
- bus_we_n is low only in ISSUE cycles of write commands. It is never low in IDLE, SAMPLE or RESP.
- Address increment is 10-bit and wraps 10'h3FF -> 10'h000.
- Per-beat cost: writes 1 cycle; reads 2 cycles plus RESP dwell (minimum 1 cycle).
- bus_oe/bus_do are ignored outside SAMPLE.
- Timer reads produce no OE from the peripheral, so they return err=1 by design. This is documented behaviour, not a fault.
- cmd_ready is 0 in every state except IDLE; commands are not queued.

Decomposition:
- Package riot_bus_pkg holds:
  - sel_e enum (SEL_ROM, SEL_RAMIO, SEL_TIMER, SEL_RSVD)
  - state_e enum (IDLE, ISSUE, SAMPLE, RESP)
  - bus-select encoding constants for the (rs_n, cs2, cs1) triples
  - default IDLE_ADDR
- No sub-module; a single FSM with address and beat counters is natural.

Test Plan:
- ROM read, sel=0, addr=10'h000, len=0, rsp_ready=1 -> bus_rs_n=0 for one cycle; rsp_valid 2 cycles after handshake; data=ROM[0], err=0, last=1.
- RAM write then read:
  - Stimulus: write sel=1, addr=10'h385, data=8'hA5; then read of the same address.
  - Write: bus_we_n low for exactly 1 cycle; one response with err=0, last=1.
  - Read: returns 8'hA5.
- Burst read with backpressure:
  - Stimulus: sel=1, addr=10'h380, len=3, with rsp_ready low for 3 cycles on beat 1.
  - Expect 4 responses for addresses 380..383, last only on the 4th.
  - Data stays stable while stalled; the bus stays idle during the stall.
- Wrap-around:
  - Stimulus: write burst sel=1, addr=10'h3FE, len=2, data=8'h5A.
  - Expect bus_a sequence 3FE, 3FF, 000 on consecutive cycles with we_n low throughout, then idle.
- Timer read and reserved sel:
  - Timer read sel=2 -> err=1, data=0.
  - sel=3 -> immediate err response with no bus_we_n/bus_a activity.
- Reset mid-burst: rst_n low during beat 2 of a len=7 read -> next edge gives the idle bus and cmd_ready=0 while reset is held, with no further responses; after release, cmd_ready=1 and a new command is accepted.
